// File: rtl/countdown_timer.sv
// Loadable, pausable down-counter with a terminal-tick BORROW output for cascading.
// Optional COUNTDOWN_AUTORELOAD_EN: the terminal tick reloads the preset and keeps running.
module countdown_timer #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic             START,
  input  logic             STOP,
  input  logic             EN,
  output logic [WIDTH-1:0] countVal,
  output logic             BORROW,
  output logic             DONE_P,
  output logic             BUSY,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } stateT;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  stateT            stateReg, stateNext;
  logic [WIDTH-1:0] countReg, countNext;
  logic             doneReg, doneNext;
  logic             busyReg;
  logic             terminalTick;

`ifdef COUNTDOWN_AUTORELOAD_EN
  logic [WIDTH-1:0] reloadReg, reloadNext;
`endif

  // A tick that actually lands on count 1 while running; STOP and LOAD steal the cycle.
  assign terminalTick = (stateReg == RUN) && EN && (countReg == ONE) && !STOP && !LOAD;

  always_comb begin
    stateNext = stateReg;
    countNext = countReg;
    doneNext  = 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
    reloadNext = reloadReg;
`endif
    if (LOAD) begin
      countNext = LOAD_VAL;
      stateNext = IDLE;
`ifdef COUNTDOWN_AUTORELOAD_EN
      reloadNext = LOAD_VAL;
`endif
    end else begin
      unique case (stateReg)
        IDLE: begin
          if (START && !STOP) begin
            if (countReg != ZERO) begin
              stateNext = RUN;
            end else begin
              stateNext = DONE;
              doneNext  = 1'b1;
            end
          end
        end
        RUN: begin
          if (STOP) begin
            stateNext = PAUSE;
          end else if (EN) begin
            if (countReg == ONE) begin
              doneNext  = 1'b1;
              countNext = ZERO;
              stateNext = DONE;
`ifdef COUNTDOWN_AUTORELOAD_EN
              if (reloadReg != ZERO) begin
                countNext = reloadReg;
                stateNext = RUN;
              end
`endif
            end else if (countReg != ZERO) begin
              countNext = countReg - ONE;
            end
          end
        end
        PAUSE: begin
          // STOP outranks START, so a simultaneous pair leaves the timer paused.
          if (START && !STOP) begin
            stateNext = RUN;
          end
        end
        DONE: begin
          countNext = ZERO;
        end
        default: begin
          stateNext = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      stateReg <= IDLE;
      countReg <= ZERO;
      doneReg  <= 1'b0;
      busyReg  <= 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
      reloadReg <= ZERO;
`endif
    end else begin
      stateReg <= stateNext;
      countReg <= countNext;
      doneReg  <= doneNext;
      busyReg  <= (stateNext == RUN);
`ifdef COUNTDOWN_AUTORELOAD_EN
      reloadReg <= reloadNext;
`endif
    end
  end

  assign countVal = countReg;
  assign BORROW   = terminalTick && !RES;
  assign DONE_P   = doneReg;
  assign BUSY     = busyReg;
  assign state    = stateReg;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: a reference model queues per-cycle expectations
// that are popped and compared after each clock edge.
module tb_countdown_timer;
  localparam int W = 16;

  logic         CLK = 1'b0;
  logic         RES, LOAD, START, STOP, EN;
  logic [W-1:0] LOAD_VAL;
  logic [W-1:0] countVal;
  logic         BORROW, DONE_P, BUSY;
  logic [1:0]   state;

  countdown_timer #(.WIDTH(W)) dut (
    .CLK(CLK), .RES(RES), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL), .START(START),
    .STOP(STOP), .EN(EN), .countVal(countVal), .BORROW(BORROW), .DONE_P(DONE_P),
    .BUSY(BUSY), .state(state)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [W-1:0] cnt;
    logic [1:0]   st;
    logic         dp;
    logic         bz;
  } expT;

  expT expQ[$];
  int total = 0;
  int bad = 0;
  int donePulses = 0;
  int borrowPulses = 0;

  logic [W-1:0] mCount = '0;
  logic [W-1:0] mReload = '0;
  logic [1:0]   mState = 2'b00;

  // One clock cycle: apply inputs, check combinational BORROW, predict and check registered outputs.
  task automatic drive(input logic res, input logic ld, input logic [W-1:0] val,
                       input logic st, input logic sp, input logic en);
    expT e;
    logic expBorrow;
    logic expDone;
    RES = res; LOAD = ld; LOAD_VAL = val; START = st; STOP = sp; EN = en;
    #1;
    expBorrow = (mState == 2'b01) && en && (mCount == 1) && !sp && !ld && !res;
    total++;
    if (BORROW !== expBorrow) begin
      bad++;
      $display("FAIL borrow: got %b want %b (count %0d)", BORROW, expBorrow, mCount);
    end
    if (BORROW === 1'b1) borrowPulses++;

    expDone = 1'b0;
    if (res) begin
      mCount = '0; mReload = '0; mState = 2'b00;
    end else if (ld) begin
      mCount = val; mReload = val; mState = 2'b00;
    end else if (mState == 2'b00) begin
      if (st && !sp) begin
        if (mCount == 0) begin mState = 2'b11; expDone = 1'b1; end
        else mState = 2'b01;
      end
    end else if (mState == 2'b01) begin
      if (sp) mState = 2'b10;
      else if (en && mCount == 1) begin
        expDone = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
        if (mReload != 0) mCount = mReload;
        else begin mCount = '0; mState = 2'b11; end
`else
        mCount = '0; mState = 2'b11;
`endif
      end else if (en && mCount > 1) mCount = mCount - 1;
    end else if (mState == 2'b10) begin
      if (st && !sp) mState = 2'b01;
    end
    e.cnt = mCount; e.st = mState; e.dp = expDone; e.bz = (mState == 2'b01);
    expQ.push_back(e);

    @(posedge CLK);
    #1;
    e = expQ.pop_front();
    total++;
    if (countVal !== e.cnt) begin
      bad++;
      $display("FAIL countVal: got %0d want %0d", countVal, e.cnt);
    end
    total++;
    if (state !== e.st) begin
      bad++;
      $display("FAIL state: got %b want %b", state, e.st);
    end
    total++;
    if (DONE_P !== e.dp) begin
      bad++;
      $display("FAIL done_p: got %b want %b", DONE_P, e.dp);
    end
    total++;
    if (BUSY !== e.bz) begin
      bad++;
      $display("FAIL busy: got %b want %b", BUSY, e.bz);
    end
    if (DONE_P === 1'b1) donePulses++;
    $display("txn res=%b ld=%b val=%0d st=%b sp=%b en=%b -> cnt=%0d state=%b dp=%b busy=%b borrow=%b",
             res, ld, val, st, sp, en, countVal, state, DONE_P, BUSY, BORROW);
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 16'h00ff, 1, 0, 1);
    total++;
    if (countVal !== 0 || state !== 2'b00 || DONE_P !== 0 || BUSY !== 0) begin
      bad++;
      $display("FAIL reset_state: got cnt=%0d st=%b dp=%b bz=%b want 0/00/0/0",
               countVal, state, DONE_P, BUSY);
    end
  endtask

  task automatic test_basic();
    donePulses = 0; borrowPulses = 0;
    drive(0, 1, 5, 0, 0, 1);
    drive(0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) drive(0, 0, 0, 1, 1, 1);
    total++;
    if (countVal !== 0 || state !== 2'b11) begin
      bad++;
      $display("FAIL basic_final: got cnt=%0d st=%b want 0/11", countVal, state);
    end
    total++;
    if (donePulses != 1 || borrowPulses != 1) begin
      bad++;
      $display("FAIL basic_pulses: got done=%0d borrow=%0d want 1/1", donePulses, borrowPulses);
    end
  endtask

  task automatic test_en_gating();
    drive(0, 1, 3, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    total++;
    if (countVal !== 1 || state !== 2'b01) begin
      bad++;
      $display("FAIL gating_mid: got cnt=%0d st=%b want 1/01", countVal, state);
    end
    drive(0, 0, 0, 0, 0, 1);
    total++;
    if (state !== 2'b11 || DONE_P !== 1'b1) begin
      bad++;
      $display("FAIL gating_done: got st=%b dp=%b want 11/1", state, DONE_P);
    end
  endtask

  task automatic test_pause();
    donePulses = 0;
    drive(0, 1, 10, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, i[0], 1);
    total++;
    if (countVal !== 6 || state !== 2'b10 || BUSY !== 1'b0) begin
      bad++;
      $display("FAIL pause_hold: got cnt=%0d st=%b bz=%b want 6/10/0", countVal, state, BUSY);
    end
    drive(0, 0, 0, 1, 0, 1);
    total++;
    if (countVal !== 6 || state !== 2'b01) begin
      bad++;
      $display("FAIL pause_resume: got cnt=%0d st=%b want 6/01", countVal, state);
    end
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 0, 1);
    total++;
    if (donePulses != 1 || state !== 2'b11) begin
      bad++;
      $display("FAIL pause_done: got pulses=%0d st=%b want 1/11", donePulses, state);
    end
  endtask

  task automatic test_load_override();
    drive(0, 1, 10, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 1);
    drive(1, 1, 16'h0033, 0, 0, 1);
    total++;
    if (countVal !== 0 || state !== 2'b00) begin
      bad++;
      $display("FAIL res_over_load: got cnt=%0d st=%b want 0/00", countVal, state);
    end
    drive(0, 1, 6, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 1, 9, 1, 0, 1);
    total++;
    if (countVal !== 9 || state !== 2'b00 || BUSY !== 1'b0) begin
      bad++;
      $display("FAIL load_midrun: got cnt=%0d st=%b bz=%b want 9/00/0", countVal, state, BUSY);
    end
  endtask

  task automatic test_zero_load();
    donePulses = 0; borrowPulses = 0;
    drive(0, 1, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 0, 1);
    total++;
    if (donePulses != 1 || borrowPulses != 0 || state !== 2'b11) begin
      bad++;
      $display("FAIL zero_load: got done=%0d borrow=%0d st=%b want 1/0/11",
               donePulses, borrowPulses, state);
    end
  endtask

  task automatic test_back_to_back();
    donePulses = 0;
    drive(0, 1, 2, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 1, 1, 0, 0, 1);
    drive(0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    total++;
    if (donePulses != 2 || countVal !== 0) begin
      bad++;
      $display("FAIL back_to_back: got pulses=%0d cnt=%0d want 2/0", donePulses, countVal);
    end
  endtask

`ifdef COUNTDOWN_AUTORELOAD_EN
  task automatic test_autoreload();
    donePulses = 0; borrowPulses = 0;
    drive(0, 1, 3, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 12; i++) drive(0, 0, 0, 0, 0, 1);
    total++;
    if (donePulses != 4 || borrowPulses != 4 || state !== 2'b01 || countVal !== 3) begin
      bad++;
      $display("FAIL autoreload: got done=%0d borrow=%0d st=%b cnt=%0d want 4/4/01/3",
               donePulses, borrowPulses, state, countVal);
    end
  endtask
`endif

  initial begin
    RES = 1'b1; LOAD = 1'b0; LOAD_VAL = '0; START = 1'b0; STOP = 1'b0; EN = 1'b0;
    test_reset();
    test_basic();
    test_en_gating();
    test_pause();
    test_load_override();
    test_zero_load();
    test_back_to_back();
`ifdef COUNTDOWN_AUTORELOAD_EN
    test_autoreload();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable, pausable down-counter timer. It is the counterpart to the team's enable-chained up-counters.
- It counts a preset value down to zero on qualified ticks, then flags completion.
- `BORROW` is a terminal-tick output for cascading timers or prescalers.
- Used as the event/interval timer beside the up-counter blocks on the lab boards.

Parameters:
- WIDTH, 16, bit width of the count and load value (legal range 2..32).

Ports:
- CLK  input  1  system clock; all state changes on posedge.
- RES  input  1  synchronous reset, active-high.
- LOAD  input  1  load strobe; samples LOAD_VAL.
- LOAD_VAL  input  WIDTH  preset value.
- START  input  1  start/resume strobe.
- STOP  input  1  pause strobe.
- EN  input  1  tick qualifier; count advances only when high. Chain from an upstream BORROW or a prescaler.
- countVal  output  WIDTH  current count (registered).
- BORROW  output  1  terminal tick, combinational.
- DONE_P  output  1  one-cycle completion pulse (registered).
- BUSY  output  1  high in RUN state (registered).
- state  output  2  FSM state: IDLE=00, RUN=01, PAUSE=10, DONE=11.

Behaviour:
- Interface (already decided): one clock CLK; reset RES is synchronous and active-high. No asynchronous logic.
- Reset (RES=1 at a posedge) sets: countVal=0, state=IDLE, DONE_P=0, BUSY=0, internal reload register=0. RES overrides every other input.
- Per-cycle input priority: RES > LOAD > STOP > START > EN tick.
- LOAD (any state): countVal<=LOAD_VAL, reload register<=LOAD_VAL, state<=IDLE, DONE_P<=0. A running count is abandoned.
- IDLE:
  - START with countVal!=0 → RUN.
  - START with countVal==0 → DONE, with DONE_P=1 for one cycle.
  - EN is ignored.
- RUN:
  - EN=1 with countVal>1 → countVal decrements by 1.
  - EN=1 with countVal==1 → countVal<=0, state<=DONE, DONE_P=1 in the next cycle only.
  - EN=0 → hold.
  - STOP → PAUSE; count held, and a same-cycle tick is discarded.
- PAUSE:
  - Count held.
  - START → RUN; ticks resume counting from the following cycle.
  - STOP is ignored.
- DONE:
  - countVal holds 0.
  - START, STOP and EN are ignored; only LOAD or RES leaves DONE.
- BORROW = (state==RUN) & EN & (countVal==1) & ~STOP & ~LOAD & ~RES. It is asserted in the same cycle as the terminal tick, so a downstream timer's EN sees exactly one tick per expiry.
- Latency:
  - Terminal tick to DONE_P/state change: 1 cycle.
  - LOAD to countVal update: 1 cycle.
- The count never wraps below 0; no decrement happens when countVal==0.
- BUSY = (state==RUN), registered alongside state.

Optional Feature:
- Macro: COUNTDOWN_AUTORELOAD_EN.
- Defined: on the terminal tick in RUN, countVal<=reload register and state stays RUN. DONE_P still pulses one cycle, and BORROW behaves as above, giving a periodic pulse every reload-value ticks.
  - If the reload register is 0, the block enters DONE as in the undefined build.
  - STOP/LOAD behave unchanged.
- Undefined: no reload; the terminal tick always enters DONE and the reload register may be optimised away.

Test Plan:
- RES=1 for 2 cycles, then LOAD_VAL=5, LOAD, START, EN=1 constant → countVal 5,4,3,2,1,0; BORROW high only in the cycle countVal==1; DONE_P high one cycle as state becomes 11; countVal stays 0 for 10 more cycles.
- LOAD 0x0003, START, EN toggling 1,0,1,0,1 → countVal decrements only on EN=1 cycles; DONE reached after the 3rd tick (cycle 5).
- LOAD 10, START, 4 ticks (count 6), STOP with EN=1 → count holds at 6 in PAUSE for 5 cycles; START → counts 5..0, DONE_P once.
- In RUN at count 7, assert RES and LOAD together → countVal=0, state=IDLE; then LOAD alone mid-run at count 4 with LOAD_VAL=9 → countVal=9, state=IDLE, BUSY=0.
- LOAD 0, START → state DONE next cycle, DONE_P one pulse, BORROW never asserted.
- With COUNTDOWN_AUTORELOAD_EN: LOAD 3, START, EN=1 for 12 cycles → countVal 3,2,1,3,2,1,…; DONE_P and BORROW pulse every 3 ticks (4 pulses); state stays RUN.
